// File: rtl/score_keeper.sv
// Game score keeper: IDLE/PLAY/OVER control, saturating 3-digit BCD score,
// survival bonus from the score-rate tick, session high score and game-over blink.

module score_bcd_digit (
   input  logic [3:0] d,
   input  logic [1:0] cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] raw;

   // cin never exceeds 2, so a single -10 correction always suffices
   always_comb begin
      raw = {1'b0, d} + {3'b000, cin};
      if (raw >= 5'd10) begin
         sum  = 4'(raw - 5'd10);
         cout = 1'b1;
      end else begin
         sum  = raw[3:0];
         cout = 1'b0;
      end
   end
endmodule

module score_keeper #(
   parameter int SURVIVE_TICKS = 8,
   parameter int BLINK_TICKS   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        start,
   input  logic        pipe_pass,
   input  logic        collide,
   output logic [11:0] score_bcd,
   output logic [11:0] high_bcd,
   output logic        playing,
   output logic        game_over,
   output logic        blank,
   output logic        new_high
);
   localparam int NUM_DIGITS = 3;
   localparam int SW = $clog2(SURVIVE_TICKS) + 1;
   localparam int BW = $clog2(BLINK_TICKS) + 1;

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t                          state, state_nxt;
   logic                            playing_d, game_over_d;
   logic                            start_game;
   logic                            over_first;
   logic                            bonus;
   logic [1:0]                      inc;
   logic [SW-1:0]                   surv_cnt;
   logic [BW-1:0]                   blink_cnt;
   logic [NUM_DIGITS-1:0][3:0]      cur_dig, sum_dig;
   logic [NUM_DIGITS-1:0]           carry;
   logic [11:0]                     score_inc;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)   state_nxt = PLAY;
         PLAY:    if (collide) state_nxt = OVER;
         OVER:    if (start)   state_nxt = PLAY;
         default:              state_nxt = IDLE;
      endcase
   end

   always_comb begin
      playing_d   = (state_nxt == PLAY);
      game_over_d = (state_nxt == OVER);
      start_game  = (state_nxt == PLAY) && (state != PLAY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         playing   <= playing_d;
         game_over <= game_over_d;
      end
   end

   // ---------------- score increment ----------------
   always_comb begin
      bonus = (state == PLAY) && tick && (surv_cnt == SW'(SURVIVE_TICKS - 1));
      inc   = {1'b0, pipe_pass} + {1'b0, bonus};
   end

   assign cur_dig = score_bcd;

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
         logic [1:0] dcin;
         if (g == 0) begin : g_lsd
            assign dcin = inc;
         end else begin : g_upper
            assign dcin = {1'b0, carry[g-1]};
         end
         score_bcd_digit u_dig (
            .d    (cur_dig[g]),
            .cin  (dcin),
            .sum  (sum_dig[g]),
            .cout (carry[g])
         );
      end
   endgenerate

   // a carry out of the hundreds digit means the true sum passed 999
   assign score_inc = carry[NUM_DIGITS-1] ? 12'h999 : sum_dig;

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         score_bcd  <= '0;
         high_bcd   <= '0;
         surv_cnt   <= '0;
         blink_cnt  <= '0;
         blank      <= 1'b0;
         new_high   <= 1'b0;
         over_first <= 1'b0;
      end else begin
         over_first <= (state == PLAY) && collide;

         if (start_game) begin
            score_bcd <= '0;
            surv_cnt  <= '0;
         end else if (state == PLAY) begin
            if (tick)     surv_cnt  <= bonus ? '0 : surv_cnt + 1'b1;
            if (!collide) score_bcd <= score_inc;
         end

         if (state == OVER && !start_game) begin
            if (tick) begin
               if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                  blink_cnt <= '0;
                  blank     <= ~blank;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
         end else begin
            blink_cnt <= '0;
            blank     <= 1'b0;
         end

         // valid-digit BCD values order the same as plain binary
         if (over_first && (score_bcd > high_bcd)) high_bcd <= score_bcd;

         new_high <= (state == OVER) && !start_game &&
                     (new_high || (over_first && (score_bcd > high_bcd)));
      end
   end
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: game flow, BCD carry/saturation,
// high-score update, blink timing and reset priority.

module tb_score_keeper;
   logic        clk = 1'b0;
   logic        reset, tick, start, pipe_pass, collide;
   logic [11:0] score_bcd, high_bcd;
   logic        playing, game_over, blank, new_high;
   int          checks = 0;
   int          errors = 0;

   score_keeper #(.SURVIVE_TICKS(8), .BLINK_TICKS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .start     (start),
      .pipe_pass (pipe_pass),
      .collide   (collide),
      .score_bcd (score_bcd),
      .high_bcd  (high_bcd),
      .playing   (playing),
      .game_over (game_over),
      .blank     (blank),
      .new_high  (new_high)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pipes(input int n);
      pipe_pass = 1'b1;
      repeat (n) cyc();
      pipe_pass = 1'b0;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) cyc();
      tick = 1'b0;
   endtask

   // tick and pipe_pass together: with the survival counter at 7 this adds 2
   task automatic tick_pipe();
      tick = 1'b1; pipe_pass = 1'b1;
      cyc();
      tick = 1'b0; pipe_pass = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; start = 1'b0; pipe_pass = 1'b0; collide = 1'b0;
      #1;
      repeat (3) cyc();
      chk("rst_score", score_bcd, 12'h000);
      chk("rst_high", high_bcd, 12'h000);
      chk("rst_playing", playing, 0);
      chk("rst_over", game_over, 0);
      chk("rst_blank", blank, 0);
      chk("rst_newhigh", new_high, 0);
      reset = 1'b0;

      // idle ignores pipe_pass
      pipes(2);
      chk("idle_score", score_bcd, 12'h000);
      chk("idle_over", game_over, 0);

      press_start();
      chk("start_playing", playing, 1);
      chk("start_over", game_over, 0);
      pipes(5);
      chk("five_score", score_bcd, 12'h005);
      chk("five_high", high_bcd, 12'h000);
      chk("five_playing", playing, 1);
      pipes(7);
      chk("g1_score", score_bcd, 12'h012);

      // collide beats pipe_pass
      collide = 1'b1; pipe_pass = 1'b1;
      cyc();
      collide = 1'b0; pipe_pass = 1'b0;
      chk("g1_over", game_over, 1);
      chk("g1_playing", playing, 0);
      chk("g1_score_held", score_bcd, 12'h012);
      chk("g1_high_pre", high_bcd, 12'h000);
      cyc();
      chk("g1_high", high_bcd, 12'h012);
      chk("g1_newhigh", new_high, 1);
      pipes(3);
      chk("over_frozen", score_bcd, 12'h012);

      ticks(3);
      chk("blink_t3", blank, 0);
      ticks(1);
      chk("blink_t4", blank, 1);
      ticks(3);
      chk("blink_t7", blank, 1);
      ticks(1);
      chk("blink_t8", blank, 0);

      press_start();
      chk("g2_playing", playing, 1);
      chk("g2_score", score_bcd, 12'h000);
      chk("g2_newhigh", new_high, 0);
      pipes(12);
      chk("g2_score12", score_bcd, 12'h012);
      // collide and start together: collide wins
      collide = 1'b1; start = 1'b1;
      cyc();
      collide = 1'b0; start = 1'b0;
      chk("g2_over", game_over, 1);
      chk("g2_playing", playing, 0);
      cyc();
      chk("g2_high", high_bcd, 12'h012);
      chk("g2_newhigh", new_high, 0);
      chk("g2_still_over", game_over, 1);

      press_start();
      chk("g3_score", score_bcd, 12'h000);
      chk("g3_blank", blank, 0);
      chk("g3_playing", playing, 1);
      pipes(97);
      chk("g3_097", score_bcd, 12'h097);
      ticks(7);
      chk("g3_no_bonus", score_bcd, 12'h097);
      tick_pipe();
      chk("g3_099", score_bcd, 12'h099);
      pipes(1);
      chk("g3_100", score_bcd, 12'h100);
      pipes(99);
      chk("g3_199", score_bcd, 12'h199);
      ticks(7);
      tick_pipe();
      chk("g3_201", score_bcd, 12'h201);
      pipes(797);
      chk("g3_998", score_bcd, 12'h998);
      ticks(7);
      tick_pipe();
      chk("g3_sat2", score_bcd, 12'h999);
      pipes(3);
      chk("g3_sat_hold", score_bcd, 12'h999);

      // reset during the high-score update cycle
      collide = 1'b1;
      cyc();
      collide = 1'b0;
      chk("g3_over", game_over, 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_upd_high", high_bcd, 12'h000);
      chk("rst_upd_newhigh", new_high, 0);
      chk("rst_upd_over", game_over, 0);
      chk("rst_upd_score", score_bcd, 12'h000);

      press_start();
      pipes(30);
      collide = 1'b1;
      cyc();
      collide = 1'b0;
      cyc();
      chk("g4_high", high_bcd, 12'h030);
      press_start();
      pipes(45);
      chk("g5_score", score_bcd, 12'h045);
      reset = 1'b1; pipe_pass = 1'b1;
      cyc();
      reset = 1'b0; pipe_pass = 1'b0;
      chk("mid_rst_score", score_bcd, 12'h000);
      chk("mid_rst_high", high_bcd, 12'h000);
      chk("mid_rst_playing", playing, 0);
      chk("mid_rst_over", game_over, 0);
      chk("mid_rst_blank", blank, 0);
      chk("mid_rst_newhigh", new_high, 0);
      pipes(3);
      chk("post_rst_score", score_bcd, 12'h000);
      chk("post_rst_playing", playing, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
